// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding, Rcon table and the forward S-box
// used by the key-schedule engine.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int WORD_W = 32;
    localparam int KEY_W  = 128;

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    localparam logic [127:0] SBOX_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        row = SBOX_ROW[b[7:4]];
        return row[8*(15 - int'(b[3:0])) +: 8];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub
);

    assign sub[31:24] = sbox(word[31:24]);
    assign sub[23:16] = sbox(word[23:16]);
    assign sub[15:8]  = sbox(word[15:8]);
    assign sub[7:0]   = sbox(word[7:0]);

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion; streams rk0..rk10 (encrypt) or, after an
// internal forward expansion, rk10..rk0 via the inverse schedule (decrypt).
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dec,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               rk_ready,
    output logic               rk_valid,
    output logic [KEY_W-1:0]   round_key,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [ROUND_W-1:0] LAST_R = ROUND_W'(NR);

    state_t               state, state_nxt;
    logic [ROUND_W-1:0]   cnt;
    logic                 dec_mode;
    logic                 accept, last_key, inv_step;
    logic [ROUND_W-1:0]   rcon_sel;
    logic [WORD_W-1:0]    w0, w1, w2, w3, p1, p2, p3, sub_in, sub_out, t;
    logic [WORD_W-1:0]    n0, n1, n2, n3;
    logic [KEY_W-1:0]     next_key;

    assign accept   = (state == EMIT) && rk_ready;
    assign last_key = dec_mode ? (round_idx == '0) : (round_idx == LAST_R);
    assign inv_step = (state == EMIT) && dec_mode;

    assign {w0, w1, w2, w3} = round_key;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // The single SubWord unit sees RotWord(w3) going forward, RotWord(p3) going back.
    assign sub_in = inv_step ? {p3[23:0], p3[31:24]} : {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        rcon_sel = round_idx + 1'b1;
        if (state == EXPAND)
            rcon_sel = cnt;
        else if (inv_step)
            rcon_sel = round_idx;
    end

    assign t  = sub_out ^ {rcon(4'(rcon_sel)), 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = inv_step ? {w0 ^ t, p1, p2, p3} : {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = dec ? EXPAND : EMIT;
            EXPAND:  if (cnt == LAST_R) state_nxt = EMIT;
            EMIT:    if (accept && last_key) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rk_valid = (state == EMIT);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_key <= '0;
            round_idx <= '0;
            cnt       <= '0;
            dec_mode  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= accept && last_key;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        dec_mode  <= dec;
                        round_idx <= '0;
                        cnt       <= {{(ROUND_W-1){1'b0}}, dec};
                    end
                end
                EXPAND: begin
                    round_key <= next_key;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_R) begin
                        round_idx <= LAST_R;
                        cnt       <= '0;
                    end
                end
                EMIT: begin
                    if (accept && !last_key) begin
                        round_key <= next_key;
                        round_idx <= dec_mode ? round_idx - 1'b1 : round_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule with an independent FIPS-197 expansion model.
`timescale 1ns/1ps
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         dec = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b1;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dec       (dec),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    exp_t         sbq[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [7:0]   sb_tbl [256];
    logic [127:0] mdl_rk [11];
    logic [127:0] obs_key [11];
    int           ready_mode = 0;
    int           stall_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: S-box from GF(2^8) inverse + affine map, FIPS-197 word recurrence.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, av;
        for (int a = 0; a < 256; a++) begin
            av  = 8'(a);
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
            sb_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sb_tbl[w[31:24]], sb_tbl[w[23:16]], sb_tbl[w[15:8]], sb_tbl[w[7:0]]};
    endfunction

    task automatic expand_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_expected(input logic [127:0] key, input logic d);
        int idx;
        expand_model(key);
        for (int r = 0; r < 11; r++) begin
            idx = d ? 10 - r : r;
            sbq.push_back('{mdl_rk[idx], 4'(idx), (r == 10)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issues start, records the expected stream and checks first-key latency.
    task automatic start_sched(input logic [127:0] key, input logic d);
        for (int r = 0; r < 11; r++) obs_key[r] = '0;
        start  = 1'b1;
        key_in = key;
        dec    = d;
        push_expected(key, d);
        tick();
        start  = 1'b0;
        key_in = rand_key();
        dec    = 1'($urandom);
        if (!d) begin
            chk("enc_first_valid", 128'(rk_valid), 128'd1);
        end else begin
            chk("dec_expand_valid", 128'(rk_valid), 128'd0);
            for (int i = 1; i < 10; i++) begin
                tick();
                chk("dec_expand_valid", 128'(rk_valid), 128'd0);
            end
            tick();
            chk("dec_first_valid", 128'(rk_valid), 128'd1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk("done_seen", 128'(done), 128'd1);
        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, 128'(rk_valid), 128'd0);
        chk({nm, "_key"}, round_key, 128'd0);
        chk({nm, "_idx"}, 128'(round_idx), 128'd0);
        chk({nm, "_busy"}, 128'(busy), 128'd0);
        chk({nm, "_done"}, 128'(done), 128'd0);
    endtask

    // Ready driver: always-ready, random, or a 3-cycle stall at idx4.
    initial begin
        forever begin
            tick();
            case (ready_mode)
                0: rk_ready = 1'b1;
                1: rk_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (rk_valid && round_idx == 4'd4 && stall_cnt < 3) begin
                        rk_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        rk_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops on every handshake, checks hold-while-stalled and done timing.
    initial begin
        logic         exp_done, prev_valid, prev_ready;
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        exp_t         e;
        exp_done = 0; prev_valid = 0; prev_ready = 0; prev_key = '0; prev_idx = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done   = 0;
                prev_valid = 0;
                prev_ready = 0;
            end else begin
                chk("done_pulse", 128'(done), 128'(exp_done));
                if (done) chk("busy_in_done", 128'(busy), 128'd0);
                if (prev_valid && !prev_ready) begin
                    chk("stall_valid", 128'(rk_valid), 128'd1);
                    chk("stall_key", round_key, prev_key);
                    chk("stall_idx", 128'(round_idx), 128'(prev_idx));
                end
                exp_done = 0;
                if (rk_valid && rk_ready) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_key: got idx %0d key %h expected none", round_idx, round_key);
                    end else begin
                        e = sbq.pop_front();
                        chk("key", round_key, e.key);
                        chk("idx", 128'(round_idx), 128'(e.idx));
                        chk("busy_emit", 128'(busy), 128'd1);
                        obs_key[round_idx] = round_key;
                        exp_done = e.last;
                    end
                end
                prev_valid = rk_valid;
                prev_ready = rk_ready;
                prev_key   = round_key;
                prev_idx   = round_idx;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] k;
        build_sbox();
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // FIPS-197 key, encrypt, always ready: 11 back-to-back valid cycles.
        ready_mode = 0;
        start_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        chk("enc_idx0_key", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int i = 1; i < 11; i++) begin
            tick();
            chk("enc_consecutive_valid", 128'(rk_valid), 128'd1);
        end
        tick();
        chk("enc_done_after_idx10", 128'(done), 128'd1);
        chk("enc_valid_low_in_done", 128'(rk_valid), 128'd0);
        wait_done();
        chk("fips_idx1", obs_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_idx10", obs_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();

        // FIPS-197 key, decrypt.
        start_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        chk("dec_first_idx", 128'(round_idx), 128'd10);
        chk("dec_first_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_done();
        chk("dec_idx0", obs_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        tick();

        // All-zero key, both directions.
        start_sched(128'h0, 1'b0);
        wait_done();
        chk("zero_idx1", obs_key[1], 128'h62636363626363636263636362636363);
        chk("zero_idx10", obs_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        tick();
        start_sched(128'h0, 1'b1);
        wait_done();
        chk("zero_dec_idx1", obs_key[1], 128'h62636363626363636263636362636363);
        chk("zero_dec_idx10", obs_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        tick();

        // Three-cycle stall at idx4.
        ready_mode = 2;
        stall_cnt  = 0;
        start_sched(rand_key(), 1'b0);
        wait_done();
        tick();
        stall_cnt = 0;
        start_sched(rand_key(), 1'b1);
        wait_done();
        chk("stall_cycles", 128'(stall_cnt), 128'd3);
        tick();

        // Random backpressure, random keys and modes.
        ready_mode = 1;
        for (int n = 0; n < 6; n++) begin
            start_sched(rand_key(), 1'($urandom));
            wait_done();
            repeat ($urandom_range(0, 2)) tick();
        end

        // start while busy is ignored.
        start_sched(rand_key(), 1'b1);
        repeat (4) tick();
        start = 1'b1; key_in = rand_key(); dec = 1'b0;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1; key_in = rand_key(); dec = 1'b1;
        tick();
        start = 1'b0;
        wait_done();

        // start in the done cycle launches a new schedule.
        ready_mode = 0;
        tick();
        start_sched(rand_key(), 1'b0);
        wait_done();
        start_sched(rand_key(), 1'b1);
        chk("busy_after_done_start", 128'(busy), 128'd1);
        wait_done();
        tick();

        // Async reset during EXPAND.
        start_sched(rand_key(), 1'b1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_expand");
        sbq.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Async reset while presenting idx5.
        start_sched(rand_key(), 1'b0);
        for (int n = 0; n < 20 && !(rk_valid && round_idx == 4'd5); n++) tick();
        chk("reached_idx5", 128'(round_idx), 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_emit");
        sbq.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Clean schedules after reset.
        k = rand_key();
        start_sched(k, 1'b0);
        wait_done();
        chk("post_reset_idx0", obs_key[0], k);
        tick();
        start_sched(k, 1'b1);
        wait_done();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
